hub_to_ieee_conv: RTL and testbench

HUB_TO_IEEE_CONV -- requirements
Module: hub_to_ieee_conv

---
 rtl/hub_pkg.sv | 34 +++
 rtl/hub_ieee_round.sv | 35 +++
 rtl/hub_to_ieee_conv.sv | 148 ++++++++++++++
 tb/tb_hub_to_ieee_conv.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub_pkg.sv
// Shared definitions for HUB <-> IEEE-754 format conversion: biases, value classes and
// the canonical quiet-NaN pattern.
package hub_pkg;

  localparam int unsigned MaxW = 64;

  typedef enum logic [2:0] {
    ClsZero,
    ClsUnder,
    ClsNormal,
    ClsInf,
    ClsNan
  } hub_class_e;

  function automatic int unsigned hub_bias(int unsigned e);
    return 32'd1 << (e - 1);
  endfunction

  function automatic int unsigned ieee_bias(int unsigned e);
    return (32'd1 << (e - 1)) - 32'd1;
  endfunction

  localparam int unsigned HubBias  = hub_bias(8);
  localparam int unsigned IeeeBias = ieee_bias(8);

  // Quiet NaN fraction for an m-bit field: MSB only; callers slice the low m bits.
  function automatic logic [MaxW-1:0] canon_nan_frac(int unsigned m);
    logic [MaxW-1:0] r;
    r        = '0;
    r[m - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/hub_ieee_round.sv
// Combinational classify and round-to-nearest-even of a HUB exponent/mantissa pair
// into IEEE-754 exponent and fraction fields.
module hub_ieee_round
  import hub_pkg::*;
#(
  parameter int unsigned M = 23,
  parameter int unsigned E = 8
) (
  input  logic [E-1:0] hub_exp,
  input  logic [M-1:0] hub_man,
  output hub_class_e   cls,
  output logic [E-1:0] ieee_exp,
  output logic [M-1:0] ieee_frac
);

  localparam logic [E-1:0] BiasDelta = E'(hub_bias(E) - ieee_bias(E));

  logic carry;

  // The dropped implicit LSB is always an exact tie: odd mantissas round up to even.
  assign {carry, ieee_frac} = {1'b0, hub_man} + (M+1)'(hub_man[0]);
  assign ieee_exp           = hub_exp - BiasDelta + E'(carry);

  always_comb begin
    cls = ClsNormal;
    if (hub_exp == '0) begin
      cls = ClsZero;
    end else if (hub_exp == E'(1)) begin
      cls = ClsUnder;
    end else if (&hub_exp) begin
      cls = (hub_man == '0) ? ClsInf : ClsNan;
    end
  end

endmodule

// File: rtl/hub_to_ieee_conv.sv
// Two-stage valid/ready converter from HUB floating point to IEEE-754.
// Sticky exception flags are built only when HUB2IEEE_FLAGS_EN is defined.
module hub_to_ieee_conv
  import hub_pkg::*;
#(
  parameter int unsigned M = 23,
  parameter int unsigned E = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [E+M:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [E+M:0]   out_data,
  output logic [2:0]     flags,
  input  logic           flag_clr
);

  localparam logic [MaxW-1:0] NanFull = canon_nan_frac(M);

  logic [M-1:0] nan_frac;
  assign nan_frac = NanFull[M-1:0];

  hub_class_e   rd_cls;
  logic [E-1:0] rd_exp;
  logic [M-1:0] rd_frac;

  hub_ieee_round #(
    .M (M),
    .E (E)
  ) u_round (
    .hub_exp   (in_data[E+M-1:M]),
    .hub_man   (in_data[M-1:0]),
    .cls       (rd_cls),
    .ieee_exp  (rd_exp),
    .ieee_frac (rd_frac)
  );

  logic         init_q;
  logic         s1_valid_q;
  logic         s1_sign_q;
  hub_class_e   s1_cls_q;
  logic [E-1:0] s1_exp_q;
  logic [M-1:0] s1_frac_q;
  logic         out_valid_q;
  logic [E+M:0] out_data_q;

  logic s2_adv;
  logic in_xfer;

  // init_q keeps in_ready low until the first clock after reset release.
  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = init_q && (!s1_valid_q || s2_adv);
  assign in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= ClsZero;
      s1_exp_q   <= '0;
      s1_frac_q  <= '0;
    end else begin
      init_q <= 1'b1;
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (in_xfer) begin
        s1_sign_q <= in_data[E+M];
        s1_cls_q  <= rd_cls;
        s1_exp_q  <= rd_exp;
        s1_frac_q <= rd_frac;
      end
    end
  end

  logic [E+M:0] asm_data;
  logic [2:0]   asm_flags;

  // Flag order: {invalid, underflow, inexact}.
  always_comb begin
    asm_data  = {s1_sign_q, s1_exp_q, s1_frac_q};
    asm_flags = 3'b001;
    unique case (s1_cls_q)
      ClsZero: begin
        asm_data  = {s1_sign_q, {(E+M){1'b0}}};
        asm_flags = 3'b000;
      end
      ClsUnder: begin
        asm_data  = {s1_sign_q, {(E+M){1'b0}}};
        asm_flags = 3'b011;
      end
      ClsInf: begin
        asm_data  = {s1_sign_q, {E{1'b1}}, {M{1'b0}}};
        asm_flags = 3'b000;
      end
      ClsNan: begin
        asm_data  = {1'b0, {E{1'b1}}, nan_frac};
        asm_flags = 3'b100;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= asm_data;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef HUB2IEEE_FLAGS_EN
  logic [2:0] s2_flags_q;
  logic [2:0] flags_q;

  // A clear in the same cycle as a transfer still leaves that transfer's flags set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_flags_q <= '0;
      flags_q    <= '0;
    end else begin
      if (s2_adv && s1_valid_q) begin
        s2_flags_q <= asm_flags;
      end
      flags_q <= (flag_clr ? 3'b000 : flags_q) |
                 ((out_valid_q && out_ready) ? s2_flags_q : 3'b000);
    end
  end

  assign flags = flags_q;
`else
  logic unused_cfg;
  assign unused_cfg = flag_clr ^ (^asm_flags);
  assign flags      = 3'b000;
`endif

endmodule

// File: tb/tb_hub_to_ieee_conv.sv
// Scoreboard bench for hub_to_ieee_conv (E=8, M=23): directed corner words, backpressure,
// mid-flight reset and randomized traffic against an arithmetic reference model.
module tb_hub_to_ieee_conv;

  localparam int unsigned M = 23;
  localparam int unsigned E = 8;
`ifdef HUB2IEEE_FLAGS_EN
  localparam logic [2:0] FlagMask = 3'b111;
`else
  localparam logic [2:0] FlagMask = 3'b000;
`endif

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [31:0] in_data   = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [2:0]  flags;
  logic        flag_clr  = 1'b0;

  hub_to_ieee_conv #(
    .M (M),
    .E (E)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flags     (flags),
    .flag_clr  (flag_clr)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  flg;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  int          cmp_cnt   = 0;
  int          err_cnt   = 0;
  int          cyc       = 0;
  logic [2:0]  mdl_flags = '0;
  bit          rand_mode = 1'b0;
  bit          stall_q   = 1'b0;
  logic [31:0] stall_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    cmp_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Value of a HUB word is (2*sig+1)/2 * 2^(e-128-23); IEEE bias is 127.
  function automatic void ref_conv(input logic [31:0] h, output logic [31:0] o,
                                   output logic [2:0] f);
    int unsigned e = h[30:23];
    int unsigned sig;
    int unsigned ie;
    if (e == 0) begin
      o = {h[31], 31'd0};
      f = 3'b000;
    end else if (e == 1) begin
      o = {h[31], 31'd0};
      f = 3'b011;
    end else if (e == 255) begin
      if (h[22:0] == 0) begin
        o = {h[31], 8'hFF, 23'd0};
        f = 3'b000;
      end else begin
        o = 32'h7FC00000;
        f = 3'b100;
      end
    end else begin
      sig = (32'd1 << 23) + h[22:0];
      if (sig % 2 == 1) sig = sig + 1;
      ie = e - 128 + 127;
      if (sig == (32'd1 << 24)) begin
        sig = sig / 2;
        ie  = ie + 1;
      end
      o = {h[31], 8'(ie), 23'(sig)};
      f = 3'b001;
    end
  endfunction

  function automatic logic [31:0] rand_word();
    logic [7:0]  e;
    logic [22:0] m;
    int k = $urandom_range(0, 9);
    m = 23'($urandom);
    case (k)
      0: e = 8'h00;
      1: e = 8'h01;
      2: e = 8'hFF;
      3: e = 8'hFE;
      4: e = 8'h02;
      5: begin
        e = 8'($urandom_range(2, 254));
        m = '1;
      end
      default: e = 8'($urandom_range(2, 254));
    endcase
    if ($urandom_range(0, 7) == 0) m = '0;
    return {1'($urandom), e, m};
  endfunction

  // Monitor: pops the scoreboard on every output transfer, tracks sticky flags.
  always @(negedge clk) begin
    if (rst_n) begin
      check("flags", {29'd0, flags}, {29'd0, mdl_flags & FlagMask});
      if (stall_q) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", out_data, stall_data);
      end
      if (rand_mode && out_ready) check("thru_in_ready", {31'd0, in_ready}, 32'd1);
      if (flag_clr) mdl_flags = '0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL unexpected_out: got %h, want no output", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("data", out_data, e.data);
          if (e.chk_lat) check("latency", cyc - e.cyc, 2);
          mdl_flags = mdl_flags | e.flg;
        end
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  always @(negedge rst_n) begin
    sb.delete();
    mdl_flags = '0;
    stall_q   = 1'b0;
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      flag_clr  = ($urandom_range(0, 31) == 0);
    end
  end

  task automatic offer(input logic [31:0] w, input bit lat);
    logic [31:0] ew;
    logic [2:0]  ef;
    bit          done = 1'b0;
    ref_conv(w, ew, ef);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready && rst_n) begin
        sb.push_back('{data: ew, flg: ef, cyc: cyc, chk_lat: lat});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %h, want 1", w);
    end
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int i = 0; i < 100 && !empty; i++) begin
      @(posedge clk);
      #1;
      empty = (sb.size() == 0) && !out_valid;
    end
    if (!empty) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_flags", {29'd0, flags}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    offer(32'h40000000, 1'b1); drain();
    offer(32'h40000001, 1'b1); drain();
    offer(32'h407FFFFF, 1'b1); drain();
    offer(32'h80000000, 1'b1); drain();
    offer(32'hFF800000, 1'b1); drain();
    offer(32'h7F800001, 1'b1); drain();
    offer(32'h00800000, 1'b1); drain();
    check("flags_sticky", {29'd0, flags}, {29'd0, 3'b111 & FlagMask});
    flag_clr = 1'b1;
    @(posedge clk);
    #1 flag_clr = 1'b0;
    check("flag_clr", {29'd0, flags}, 32'd0);

    // Backpressure: two words fill the pipe, the third must wait.
    out_ready = 1'b0;
    offer(32'h40400000, 1'b0);
    offer(32'hC0A00001, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h41234567;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    offer(32'h41234567, 1'b0);
    drain();

    // Reset with two words in flight.
    offer(32'h40000003, 1'b0);
    offer(32'h40000005, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_flags", {29'd0, flags}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 check("in_ready_after_mid_rst", {31'd0, in_ready}, 32'd1);
    repeat (5) @(posedge clk);
    #1 check("no_stale_out", {31'd0, out_valid}, 32'd0);

    rand_mode = 1'b1;
    for (int n = 0; n < 1000; n++) offer(rand_word(), 1'b0);
    rand_mode = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    flag_clr  = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

endmodule
